calc_param: RTL

//  Parametrised 4-function decimal calculator core: keypad-code input, DIGITS-wide decimal operands,
//  add/sub/multi-cycle multiply, overflow/underflow detection, serial per-digit display output.

---
 rtl/calc_param_if.sv | 21 ++
 rtl/calc_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_param_if.sv
// rtl/calc_param_if.sv - keypad command and display bus for calc_param
interface calc_param_if #(
  parameter int POS_W = 3
) ();
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic [1:0]       status;
  logic [3:0]       data;
  logic [POS_W-1:0] pos;
  logic             data_valid;

  modport master (
    output cmd, cmd_valid,
    input  status, data, pos, data_valid
  );

  modport slave (
    input  cmd, cmd_valid,
    output status, data, pos, data_valid
  );
endinterface

// File: rtl/calc_param.sv
// rtl/calc_param.sv - decimal four-function calculator core with serial digit display
module calc_param #(
  parameter int DIGITS = 8,
  parameter int VAL_W  = 27,
  parameter int POS_W  = 3
) (
  input logic         clock,
  input logic         reset,
  calc_param_if.slave bus
);

  localparam int PW    = 2 * VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] MAX_VAL   = VAL_W'(10**DIGITS - 1);
  localparam logic [VAL_W-1:0] TOP_DIGIT = VAL_W'(10**(DIGITS-1));
  localparam logic [VAL_W-1:0] TEN       = VAL_W'(10);

  localparam logic [3:0] K_ADD   = 4'd10;
  localparam logic [3:0] K_SUB   = 4'd11;
  localparam logic [3:0] K_MUL   = 4'd12;
  localparam logic [3:0] K_CLEAR = 4'd13;
  localparam logic [3:0] K_EQ    = 4'd14;
  localparam logic [3:0] K_BACK  = 4'd15;

  typedef enum logic [2:0] {S_ENTRY_A, S_ENTRY_B, S_MUL, S_PRINT, S_ERROR} state_t;

  state_t           state, state_n, ret, ret_n;
  logic [VAL_W-1:0] a, a_n, entry, entry_n, pval, pval_n, mplier, mplier_n;
  logic [3:0]       op, op_n;
  logic             chained, chained_n;
  logic [POS_W-1:0] pcnt, pcnt_n;
  logic [PW-1:0]    prod, prod_n, mcand, mcand_n;
  logic [CNT_W-1:0] mcnt, mcnt_n;
  logic [VAL_W:0]   sum;
  logic             go_print, clear_all;

  // State register plus the state to resume after a print burst
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_ENTRY_A;
      ret   <= S_ENTRY_A;
    end else begin
      state <= state_n;
      ret   <= ret_n;
    end
  end

  // Operand, accumulator and print registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a       <= '0;
      entry   <= '0;
      op      <= '0;
      chained <= 1'b0;
      pval    <= '0;
      pcnt    <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mcnt    <= '0;
    end else begin
      a       <= a_n;
      entry   <= entry_n;
      op      <= op_n;
      chained <= chained_n;
      pval    <= pval_n;
      pcnt    <= pcnt_n;
      prod    <= prod_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      mcnt    <= mcnt_n;
    end
  end

  // Key decode, arithmetic and next-state selection
  always_comb begin
    state_n   = state;
    ret_n     = ret;
    a_n       = a;
    entry_n   = entry;
    op_n      = op;
    chained_n = chained;
    pval_n    = pval;
    pcnt_n    = pcnt;
    prod_n    = prod;
    mcand_n   = mcand;
    mplier_n  = mplier;
    mcnt_n    = mcnt;
    go_print  = 1'b0;
    clear_all = 1'b0;
    sum       = {1'b0, a} + {1'b0, entry};

    case (state)
      S_ENTRY_A, S_ENTRY_B: begin
        if (bus.cmd_valid) begin
          if (bus.cmd <= 4'd9) begin
            // A digit after a result starts a fresh number instead of appending
            if (chained) begin
              entry_n   = VAL_W'(bus.cmd);
              chained_n = 1'b0;
            end else if (entry < TOP_DIGIT) begin
              entry_n = entry * TEN + VAL_W'(bus.cmd);
            end
            go_print = 1'b1;
            ret_n    = state;
          end else begin
            case (bus.cmd)
              K_ADD, K_SUB, K_MUL: begin
                if (state == S_ENTRY_A) begin
                  a_n       = entry;
                  entry_n   = '0;
                  chained_n = 1'b0;
                end
                op_n     = bus.cmd;
                go_print = 1'b1;
                ret_n    = S_ENTRY_B;
              end
              K_CLEAR: begin
                clear_all = 1'b1;
                go_print  = 1'b1;
                ret_n     = S_ENTRY_A;
              end
              K_BACK: begin
                entry_n   = entry / TEN;
                chained_n = 1'b0;
                go_print  = 1'b1;
                ret_n     = state;
              end
              K_EQ: begin
                if (state == S_ENTRY_B) begin
                  ret_n = S_ENTRY_A;
                  if (op == K_MUL) begin
                    mcand_n  = PW'(a);
                    mplier_n = entry;
                    prod_n   = '0;
                    mcnt_n   = '0;
                    state_n  = S_MUL;
                  end else if (op == K_ADD) begin
                    if (sum > {1'b0, MAX_VAL}) begin
                      state_n = S_ERROR;
                    end else begin
                      entry_n   = sum[VAL_W-1:0];
                      chained_n = 1'b1;
                      go_print  = 1'b1;
                    end
                  end else begin
                    if (a < entry) begin
                      state_n = S_ERROR;
                    end else begin
                      entry_n   = a - entry;
                      chained_n = 1'b1;
                      go_print  = 1'b1;
                    end
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle; product is kept double width so overflow is exact
        prod_n   = prod + (mplier[0] ? mcand : '0);
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        mcnt_n   = mcnt + CNT_W'(1);
        if (mcnt == CNT_W'(VAL_W - 1)) begin
          if (prod_n > PW'(MAX_VAL)) begin
            state_n = S_ERROR;
          end else begin
            entry_n   = prod_n[VAL_W-1:0];
            chained_n = 1'b1;
            go_print  = 1'b1;
          end
        end
      end
      S_PRINT: begin
        pval_n = pval / TEN;
        pcnt_n = pcnt + POS_W'(1);
        if (pcnt == POS_W'(DIGITS - 1)) begin
          pcnt_n  = '0;
          state_n = ret;
        end
      end
      S_ERROR: begin
        if (bus.cmd_valid && bus.cmd == K_CLEAR) begin
          clear_all = 1'b1;
          go_print  = 1'b1;
          ret_n     = S_ENTRY_A;
        end
      end
      default: state_n = S_ENTRY_A;
    endcase

    if (clear_all) begin
      a_n       = '0;
      entry_n   = '0;
      op_n      = '0;
      chained_n = 1'b0;
    end

    if (go_print) begin
      state_n = S_PRINT;
      pval_n  = entry_n;
      pcnt_n  = '0;
    end
  end

  // Status and display outputs decoded from the current state
  always_comb begin
    bus.status     = 2'b10;
    bus.data       = 4'd0;
    bus.pos        = '0;
    bus.data_valid = 1'b0;
    case (state)
      S_MUL:   bus.status = 2'b01;
      S_ERROR: bus.status = 2'b00;
      S_PRINT: begin
        bus.status     = 2'b11;
        bus.data_valid = 1'b1;
        bus.pos        = pcnt;
        bus.data       = 4'(pval % TEN);
      end
      default: bus.status = 2'b10;
    endcase
  end

endmodule
